// File: rtl/sddr_phy_sequencer_if.sv
// Command, write-data, PHY and read-return signals between the DDR controller and the DQ/DQS sequencer.
// slave is the sequencer's view; master is the controller/PHY side.
interface sddr_phy_sequencer_if #(
  parameter int DATA_BITS = 16
);
  logic                          cmd_valid_i;
  logic                          cmd_write_i;
  logic                          cmd_ready_o;
  logic [1:0][DATA_BITS-1:0]     wr_dq_i;
  logic                          wr_data_req_o;
  logic [1:0][DATA_BITS-1:0]     phy_dq_o;
  logic                          dq_oe_o;
  logic                          dqs_oe_o;
  logic                          odt_o;
  logic                          rd_capture_o;
  logic [1:0][DATA_BITS-1:0]     phy_dq_i;
  logic [1:0][DATA_BITS-1:0]     rd_dq_o;
  logic                          rd_valid_o;
  logic                          rd_last_o;
  logic                          busy_o;
  logic                          err_o;

  modport slave (
    input  cmd_valid_i, cmd_write_i, wr_dq_i, phy_dq_i,
    output cmd_ready_o, wr_data_req_o, phy_dq_o, dq_oe_o, dqs_oe_o, odt_o,
           rd_capture_o, rd_dq_o, rd_valid_o, rd_last_o, busy_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, wr_dq_i, phy_dq_i,
    input  cmd_ready_o, wr_data_req_o, phy_dq_o, dq_oe_o, dqs_oe_o, odt_o,
           rd_capture_o, rd_dq_o, rd_valid_o, rd_last_o, busy_o, err_o
  );
endinterface

// File: rtl/sddr_phy_sequencer.sv
// CAS command -> cycle-exact DQ/DQS enables, ODT, write-data requests and read-capture windows.
// Latency = run-time rl/wl; commands are refused (cmd_ready_o low) until bus-turnaround spacing expires.
module sddr_phy_sequencer #(
  parameter  int DATA_BITS    = 16,
  parameter  int MAX_LAT      = 16,
  parameter  int BURST_CYCLES = 4,
  localparam int LAT_BITS     = $clog2(MAX_LAT + 1)
) (
  input  logic                in_ddr_clock_i,
  input  logic                in_phy_reset_i,
  input  logic [LAT_BITS-1:0] cfg_rd_lat_i,
  input  logic [LAT_BITS-1:0] cfg_wr_lat_i,
  sddr_phy_sequencer_if.slave bus
);
  localparam int DEPTH = MAX_LAT + BURST_CYCLES + 2;
  localparam int HW    = LAT_BITS + 2;

  typedef logic signed [HW-1:0]      hold_t;
  typedef logic [1:0][DATA_BITS-1:0] dq_t;

  localparam hold_t ONE_H = hold_t'(1);
  localparam hold_t BC_H  = hold_t'(BURST_CYCLES);
  localparam hold_t BC2_H = hold_t'(BURST_CYCLES + 2);

  function automatic hold_t smax(input hold_t a, input hold_t b);
    return (a > b) ? a : b;
  endfunction

  logic [LAT_BITS-1:0] r_rl, r_wl;
  logic [DEPTH-1:0]    r_rd_sr, r_rd_last_sr, r_wr_sr;
  logic                r_rd_valid, r_rd_last, r_dq_oe, r_dqs_oe, r_err;
  dq_t                 r_rd_dq;
  hold_t               r_rd_hold, r_wr_hold;

  logic             w_ready, w_rd_acc, w_wr_acc, w_busy;
  logic [DEPTH-1:0] w_rd_load, w_rd_last_load, w_wr_load, w_wr_sr_nxt;
  hold_t            w_rl_s, w_wl_s, w_rd_hold_nxt, w_wr_hold_nxt;
  int               w_rl_i, w_wl_i;

  assign w_ready  = !in_phy_reset_i &&
                    ((bus.cmd_write_i ? r_wr_hold : r_rd_hold) == '0);
  assign w_rd_acc = bus.cmd_valid_i && w_ready && !bus.cmd_write_i;
  assign w_wr_acc = bus.cmd_valid_i && w_ready &&  bus.cmd_write_i;

  assign w_busy = (|r_rd_sr) || (|r_rd_last_sr) || (|r_wr_sr) || r_rd_valid ||
                  r_dq_oe || r_dqs_oe || (r_rd_hold != '0) || (r_wr_hold != '0);

  assign w_rl_i = int'(r_rl);
  assign w_wl_i = int'(r_wl);
  assign w_rl_s = $signed({2'b00, r_rl});
  assign w_wl_s = $signed({2'b00, r_wl});

  // Bit k of a line reaches bit 0 (the output) k+1 clocks after the command clock.
  always_comb begin
    w_rd_load      = '0;
    w_rd_last_load = '0;
    w_wr_load      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_rd_load[k]      = w_rd_acc && (k + 1 >= w_rl_i) && (k + 1 <= w_rl_i + BURST_CYCLES - 1);
      w_rd_last_load[k] = w_rd_acc && (k + 1 == w_rl_i + BURST_CYCLES - 1);
      w_wr_load[k]      = w_wr_acc && (k + 2 >= w_wl_i) && (k + 2 <= w_wl_i + BURST_CYCLES - 1);
    end
  end

  assign w_wr_sr_nxt = (r_wr_sr >> 1) | w_wr_load;

  // Turnaround spacing: the opposite-direction counter covers latency skew plus a 2-clock bus gap.
  always_comb begin
    w_rd_hold_nxt = (r_rd_hold != '0) ? r_rd_hold - ONE_H : '0;
    w_wr_hold_nxt = (r_wr_hold != '0) ? r_wr_hold - ONE_H : '0;
    if (w_rd_acc) begin
      w_rd_hold_nxt = smax(w_rd_hold_nxt, BC_H - ONE_H);
      w_wr_hold_nxt = smax(w_wr_hold_nxt, smax(BC_H, w_rl_s + BC2_H - w_wl_s) - ONE_H);
    end else if (w_wr_acc) begin
      w_wr_hold_nxt = smax(w_wr_hold_nxt, BC_H - ONE_H);
      w_rd_hold_nxt = smax(w_rd_hold_nxt, smax(BC_H, w_wl_s + BC2_H - w_rl_s) - ONE_H);
    end
  end

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_phy_reset_i) begin
      r_rl         <= cfg_rd_lat_i;
      r_wl         <= cfg_wr_lat_i;
      r_rd_sr      <= '0;
      r_rd_last_sr <= '0;
      r_wr_sr      <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_dq      <= '0;
      r_dq_oe      <= 1'b0;
      r_dqs_oe     <= 1'b0;
      r_rd_hold    <= '0;
      r_wr_hold    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (!w_busy) begin
        r_rl <= cfg_rd_lat_i;
        r_wl <= cfg_wr_lat_i;
      end
      r_rd_sr      <= (r_rd_sr >> 1) | w_rd_load;
      r_rd_last_sr <= (r_rd_last_sr >> 1) | w_rd_last_load;
      r_wr_sr      <= w_wr_sr_nxt;
      r_rd_valid   <= r_rd_sr[0];
      r_rd_last    <= r_rd_last_sr[0];
      r_rd_dq      <= r_rd_sr[0] ? bus.phy_dq_i : '0;
      r_dq_oe      <= r_wr_sr[0];
      // Preamble from the request clock, postamble one clock past dq_oe; adjacent bursts merge.
      r_dqs_oe     <= w_wr_sr_nxt[0] || r_wr_sr[0] || r_dq_oe;
      r_rd_hold    <= w_rd_hold_nxt;
      r_wr_hold    <= w_wr_hold_nxt;
      if (bus.cmd_valid_i && !w_ready) r_err <= 1'b1;
    end
  end

  assign bus.cmd_ready_o   = w_ready;
  assign bus.wr_data_req_o = r_wr_sr[0];
  assign bus.phy_dq_o      = r_wr_sr[0] ? bus.wr_dq_i : '0;
  assign bus.dq_oe_o       = r_dq_oe;
  assign bus.dqs_oe_o      = r_dqs_oe;
  assign bus.odt_o         = r_dqs_oe;
  assign bus.rd_capture_o  = r_rd_sr[0];
  assign bus.rd_dq_o       = r_rd_dq;
  assign bus.rd_valid_o    = r_rd_valid;
  assign bus.rd_last_o     = r_rd_last;
  assign bus.busy_o        = w_busy;
  assign bus.err_o         = r_err;
endmodule

// File: tb/tb_sddr_phy_sequencer.sv
// Bench for sddr_phy_sequencer at rl=6, wl=5, BC=4: per-cycle window checks plus a read-return scoreboard.
module tb_sddr_phy_sequencer;
  localparam int DB = 16;
  localparam int ML = 16;
  localparam int BC = 4;
  localparam int LB = $clog2(ML + 1);
  localparam int RL = 6;
  localparam int WL = 5;

  typedef logic [1:0][DB-1:0] dq_t;
  typedef struct {
    int  due;
    dq_t dat;
    logic last;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LB-1:0] cfg_rl = LB'(RL);
  logic [LB-1:0] cfg_wl = LB'(WL);
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  rd_exp_t       sb[$];

  sddr_phy_sequencer_if #(.DATA_BITS(DB)) bus();

  sddr_phy_sequencer #(.DATA_BITS(DB), .MAX_LAT(ML), .BURST_CYCLES(BC)) dut (
    .in_ddr_clock_i(clk),
    .in_phy_reset_i(rst),
    .cfg_rd_lat_i  (cfg_rl),
    .cfg_wr_lat_i  (cfg_wl),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DB-1:0] rpat(input int c);
    return (2*DB)'(c * 40503) ^ 32'h5a5a_c3c3;
  endfunction

  function automatic logic [2*DB-1:0] wpat(input int c);
    return (2*DB)'(c * 2654435) ^ 32'h0f0f_3c3c;
  endfunction

  // PHY read data and controller write data are a known function of the cycle number.
  initial begin
    bus.phy_dq_i = rpat(0);
    bus.wr_dq_i  = wpat(0);
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.phy_dq_i = rpat(cyc);
      bus.wr_dq_i  = wpat(cyc);
    end
  end

  // Read-return scoreboard.
  always @(negedge clk) begin
    rd_exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_vec++; n_err++;
      $display("FAIL rd_missing: no rd_valid_o at cycle %0d, required one", sb[0].due);
      void'(sb.pop_front());
    end
    if (bus.rd_valid_o === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rd_extra: rd_valid_o=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.due || bus.rd_dq_o !== e.dat || bus.rd_last_o !== e.last) begin
          n_err++;
          $display("FAIL rd_beat: cycle %0d dq %h last %b, required cycle %0d dq %h last %b",
                   cyc, bus.rd_dq_o, bus.rd_last_o, e.due, e.dat, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input int t, input int rl);
    for (int i = 0; i < BC; i++)
      sb.push_back(rd_exp_t'{t + rl + 1 + i, dq_t'(rpat(t + rl + i)), (i == BC - 1)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = {bus.cmd_ready_o, bus.wr_data_req_o, bus.dq_oe_o, bus.dqs_oe_o, bus.odt_o,
           bus.rd_capture_o, bus.rd_valid_o, bus.rd_last_o, bus.busy_o, bus.err_o};
      n_vec++;
      if (o !== '0 || bus.phy_dq_o !== '0 || bus.rd_dq_o !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: flags %b phy_dq %h rd_dq %h, required all 0", o, bus.phy_dq_o, bus.rd_dq_o);
      end
      step();
    end
    rst = 1'b0;
    bus.cmd_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL reset_idle: busy %b err %b ready %b, required 0 0 1", bus.busy_o, bus.err_o, bus.cmd_ready_o);
      end
      step();
    end
  endtask

  task automatic test_read();
    for (int c = 0; c < 14; c++) begin
      bus.cmd_valid_i = (c == 0);
      bus.cmd_write_i = 1'b0;
      if (c == 0) push_read(cyc, RL);
      @(negedge clk);
      n_vec++;
      if (bus.rd_capture_o !== (c >= 6 && c <= 9) || bus.busy_o !== (c >= 1 && c <= 10)) begin
        n_err++;
        $display("FAIL read_window c=%0d: capture %b busy %b, required %b %b", c,
                 bus.rd_capture_o, bus.busy_o, (c >= 6 && c <= 9), (c >= 1 && c <= 10));
      end
      if (c == 0) begin
        n_vec++;
        if (bus.cmd_ready_o !== 1'b1) begin
          n_err++;
          $display("FAIL read_ready: cmd_ready_o %b, required 1", bus.cmd_ready_o);
        end
      end
      step();
    end
  endtask

  task automatic test_write();
    logic [3:0] got, exp;
    dq_t        exp_dq;
    for (int c = 0; c < 13; c++) begin
      bus.cmd_valid_i = (c == 0);
      bus.cmd_write_i = 1'b1;
      @(negedge clk);
      got    = {bus.wr_data_req_o, bus.dq_oe_o, bus.dqs_oe_o, bus.odt_o};
      exp    = {c >= 4 && c <= 7, c >= 5 && c <= 8, c >= 4 && c <= 9, c >= 4 && c <= 9};
      exp_dq = (c >= 4 && c <= 7) ? dq_t'(wpat(cyc)) : '0;
      n_vec++;
      if (got !== exp || bus.phy_dq_o !== exp_dq || bus.rd_capture_o !== 1'b0) begin
        n_err++;
        $display("FAIL write_window c=%0d: req/oe/dqs/odt %b dq %h cap %b, required %b %h 0",
                 c, got, bus.phy_dq_o, bus.rd_capture_o, exp, exp_dq);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    for (int c = 0; c < 17; c++) begin
      bus.cmd_valid_i = (c == 0 || c == 4);
      bus.cmd_write_i = 1'b1;
      @(negedge clk);
      got = {bus.wr_data_req_o, bus.dq_oe_o, bus.dqs_oe_o, bus.odt_o};
      exp = {c >= 4 && c <= 11, c >= 5 && c <= 12, c >= 4 && c <= 13, c >= 4 && c <= 13};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_window c=%0d: req/oe/dqs/odt %b, required %b", c, got, exp);
      end
      if (c == 4) begin
        n_vec++;
        if (bus.cmd_ready_o !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready: cmd_ready_o %b at c=4, required 1", bus.cmd_ready_o);
        end
      end
      step();
    end
  endtask

  task automatic test_turnaround();
    logic [3:0] got, exp;
    for (int c = 0; c < 20; c++) begin
      bus.cmd_valid_i = (c <= 7);
      bus.cmd_write_i = (c >= 1);
      if (c == 0) push_read(cyc, RL);
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        n_vec++;
        if (bus.cmd_ready_o !== (c == 7)) begin
          n_err++;
          $display("FAIL turn_ready c=%0d: cmd_ready_o %b, required %b", c, bus.cmd_ready_o, (c == 7));
        end
      end
      got = {bus.wr_data_req_o, bus.dq_oe_o, bus.dqs_oe_o, bus.odt_o};
      exp = {c >= 11 && c <= 14, c >= 12 && c <= 15, c >= 11 && c <= 16, c >= 11 && c <= 16};
      n_vec++;
      if (got !== exp || bus.err_o !== (c >= 2)) begin
        n_err++;
        $display("FAIL turn_window c=%0d: req/oe/dqs/odt %b err %b, required %b %b", c, got, bus.err_o, exp, (c >= 2));
      end
      step();
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      bus.cmd_valid_i = (c == 0 || c == 2);
      bus.cmd_write_i = 1'b0;
      if (c == 0) push_read(cyc, RL);
      @(negedge clk);
      if (c == 2) begin
        n_vec++;
        if (bus.cmd_ready_o !== 1'b0) begin
          n_err++;
          $display("FAIL drop_ready: cmd_ready_o %b at c=2, required 0", bus.cmd_ready_o);
        end
      end
      n_vec++;
      if (bus.err_o !== (c >= 3) || bus.rd_capture_o !== (c >= 6 && c <= 9)) begin
        n_err++;
        $display("FAIL drop_window c=%0d: err %b capture %b, required %b %b", c,
                 bus.err_o, bus.rd_capture_o, (c >= 3), (c >= 6 && c <= 9));
      end
      step();
    end
  endtask

  task automatic test_reset_midburst();
    logic [9:0] o;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      bus.cmd_valid_i = (c == 0 || c == 10);
      bus.cmd_write_i = 1'b0;
      rst = (c == 7 || c == 8);
      if (c == 2) cfg_rl = LB'(3);
      if (c == 8) sb.delete();
      if (c == 0) push_read(cyc, RL);
      if (c == 10) push_read(cyc, 3);
      @(negedge clk);
      o = {bus.cmd_ready_o, bus.wr_data_req_o, bus.dq_oe_o, bus.dqs_oe_o, bus.odt_o,
           bus.rd_capture_o, bus.rd_valid_o, bus.rd_last_o, bus.busy_o, bus.err_o};
      if (c == 6) begin
        n_vec++;
        if (bus.rd_capture_o !== 1'b1) begin
          n_err++;
          $display("FAIL midburst_latency: capture %b at c=6, required 1", bus.rd_capture_o);
        end
      end
      if (c == 8) begin
        n_vec++;
        if (o !== '0 || bus.rd_dq_o !== '0) begin
          n_err++;
          $display("FAIL midburst_reset: flags %b rd_dq %h, required all 0", o, bus.rd_dq_o);
        end
      end
      if (c == 9) begin
        n_vec++;
        if (o[8:0] !== '0) begin
          n_err++;
          $display("FAIL midburst_after: flags %b, required 0 apart from cmd_ready_o", o);
        end
      end
      if (c >= 9) begin
        n_vec++;
        if (bus.rd_capture_o !== (c >= 13 && c <= 16)) begin
          n_err++;
          $display("FAIL midburst_newlat c=%0d: capture %b, required %b", c, bus.rd_capture_o, (c >= 13 && c <= 16));
        end
      end
      step();
    end
    cfg_rl = LB'(RL);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_turnaround();
    test_drop();
    test_reset_midburst();
    step();
    step();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d read beats outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish by 200000, required completion");
    $fatal(1, "timeout");
  end
endmodule
